// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: register enables and clears, E-stage forwarding selects,
// and a wait FSM for the multi-cycle data memory with timeout and a saturating stall counter.
module hazard_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_D,
  input  logic [ADDR_W-1:0] rs2_D,
  input  logic [ADDR_W-1:0] rs1_E,
  input  logic [ADDR_W-1:0] rs2_E,
  input  logic [ADDR_W-1:0] rd_E,
  input  logic              memRead_E,
  input  logic              pcSrc_E,
  input  logic [ADDR_W-1:0] rd_M,
  input  logic [ADDR_W-1:0] rd_W,
  input  logic              regWrite_M,
  input  logic              regWrite_W,
  input  logic              memAccess_M,
  input  logic              memReady,
  output logic              en_F,
  output logic              en_D,
  output logic              en_E,
  output logic              en_M,
  output logic              clr_D,
  output logic              clr_E,
  output logic              clr_W,
  output logic [1:0]        fwdA_E,
  output logic [1:0]        fwdB_E,
  output logic              memErr,
  output logic [CNT_W-1:0]  stallCount
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_e;

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic load_use;
  logic mem_stall;

  assign load_use  = memRead_E && (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
  assign mem_stall = memAccess_M && !memReady;

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] rs);
    if (regWrite_M && (rd_M != '0) && (rd_M == rs))      fwd_sel = 2'b10;
    else if (regWrite_W && (rd_W != '0) && (rd_W == rs)) fwd_sel = 2'b01;
    else                                                 fwd_sel = 2'b00;
  endfunction

  always_comb begin
    en_F   = 1'b1;
    en_D   = 1'b1;
    en_E   = 1'b1;
    en_M   = 1'b1;
    clr_D  = 1'b0;
    clr_E  = 1'b0;
    clr_W  = 1'b0;
    fwdA_E = 2'b00;
    fwdB_E = 2'b00;
    if (!rst) begin
      fwdA_E = fwd_sel(rs1_E);
      fwdB_E = fwd_sel(rs2_E);
      if (state_q == ERR) begin
        {en_F, en_D, en_E, en_M} = 4'b0000;
      end else if (mem_stall) begin
        // Freeze everything up to M and push a bubble into W; branch/load-use wait for release.
        {en_F, en_D, en_E, en_M} = 4'b0000;
        clr_W = 1'b1;
      end else if (pcSrc_E) begin
        clr_D = 1'b1;
        clr_E = 1'b1;
      end else if (load_use) begin
        en_F  = 1'b0;
        en_D  = 1'b0;
        clr_E = 1'b1;
      end
    end
  end

  assign stall_cnt_d = (!en_F && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        IDLE: begin
          if (mem_stall) begin
            state_q    <= WAIT;
            wait_cnt_q <= WCNT_ONE;
          end
        end
        WAIT: begin
          if (memReady || !memAccess_M) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WCNT_LAST) begin
            state_q <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_ONE;
          end
        end
        default: begin
          // Absorbing; the flag follows one cycle behind the state.
          state_q   <= ERR;
          mem_err_q <= 1'b1;
        end
      endcase
    end
  end

  assign memErr     = mem_err_q;
  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic against a rule-level model.
module tb_hazard_ctrl;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic memRead_E, pcSrc_E, regWrite_M, regWrite_W, memAccess_M, memReady;

  logic en_F, en_D, en_E, en_M, clr_D, clr_E, clr_W, memErr;
  logic [1:0] fwdA_E, fwdB_E;
  logic [15:0] stallCount;

  logic s_en_F, s_en_D, s_en_E, s_en_M, s_clr_D, s_clr_E, s_clr_W, s_memErr;
  logic [1:0] s_fwdA_E, s_fwdB_E;
  logic [2:0] s_stallCount;

  int checks = 0;
  int errors = 0;

  // Model state: in-error flag, consecutive stall run, cycles spent in error, stall counts.
  bit m_err;
  int m_run, m_errd, m_cnt, m_cnt3;

  always #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(5), .MEM_TIMEOUT(T), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W), .memAccess_M(memAccess_M),
    .memReady(memReady), .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M),
    .clr_D(clr_D), .clr_E(clr_E), .clr_W(clr_W), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
    .memErr(memErr), .stallCount(stallCount)
  );

  hazard_ctrl #(.ADDR_W(5), .MEM_TIMEOUT(T), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .memRead_E(memRead_E), .pcSrc_E(pcSrc_E), .rd_M(rd_M), .rd_W(rd_W),
    .regWrite_M(regWrite_M), .regWrite_W(regWrite_W), .memAccess_M(memAccess_M),
    .memReady(memReady), .en_F(s_en_F), .en_D(s_en_D), .en_E(s_en_E), .en_M(s_en_M),
    .clr_D(s_clr_D), .clr_E(s_clr_E), .clr_W(s_clr_W), .fwdA_E(s_fwdA_E), .fwdB_E(s_fwdB_E),
    .memErr(s_memErr), .stallCount(s_stallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rst) return 2'b00;
    if (regWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
    if (regWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {en_F,en_D,en_E,en_M,clr_D,clr_E,clr_W} from the priority rules.
  function automatic logic [6:0] m_ctrl();
    bit stall, lu;
    stall = memAccess_M && !memReady;
    lu    = memRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
    if (rst)          return 7'b1111_000;
    if (m_err)        return 7'b0000_000;
    if (stall)        return 7'b0000_001;
    if (pcSrc_E)      return 7'b1111_110;
    if (lu)           return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  task automatic clear_inputs();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
    memRead_E = 0; pcSrc_E = 0; regWrite_M = 0; regWrite_W = 0;
    memAccess_M = 0; memReady = 0;
  endtask

  // Inputs are already driven (after negedge); check, then advance model across posedge.
  task automatic step(input string tag);
    logic [6:0] ec;
    bit stall;
    #1;
    ec = m_ctrl();
    stall = memAccess_M && !memReady;
    chk({tag, ".ctrl"}, {25'd0, en_F, en_D, en_E, en_M, clr_D, clr_E, clr_W}, {25'd0, ec});
    chk({tag, ".sat_ctrl"}, {25'd0, s_en_F, s_en_D, s_en_E, s_en_M, s_clr_D, s_clr_E, s_clr_W}, {25'd0, ec});
    chk({tag, ".fwdA"}, {30'd0, fwdA_E}, {30'd0, m_fwd(rs1_E)});
    chk({tag, ".fwdB"}, {30'd0, fwdB_E}, {30'd0, m_fwd(rs2_E)});
    chk({tag, ".memErr"}, {31'd0, memErr}, {31'd0, m_errd >= 1});
    chk({tag, ".stallCount"}, {16'd0, stallCount}, m_cnt);
    chk({tag, ".sat_stallCount"}, {29'd0, s_stallCount}, m_cnt3);
    @(posedge clk);
    if (rst) begin
      m_err = 0; m_run = 0; m_errd = 0; m_cnt = 0; m_cnt3 = 0;
    end else begin
      if (!ec[6]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      m_errd = m_err ? m_errd + 1 : 0;
      if (!m_err) begin
        if (stall) begin
          m_run++;
          if (m_run == T) m_err = 1;
        end else m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    m_err = 0; m_run = 0; m_errd = 0; m_cnt = 0; m_cnt3 = 0;
    @(negedge clk);

    // Reset forces outputs even with hazards present.
    memRead_E = 1; rd_E = 5; rs1_D = 5; memAccess_M = 1; regWrite_M = 1; rd_M = 2; rs1_E = 2;
    step("reset_forced");
    chk("reset_enF", {31'd0, en_F}, 32'd1);
    clear_inputs(); rst = 0;
    step("idle");

    // Load-use stall, then rd_E=0 must not stall.
    memRead_E = 1; rd_E = 5; rs1_D = 5;
    step("loaduse");
    memRead_E = 0;
    step("loaduse_release");
    chk("loaduse_count", {16'd0, stallCount}, 32'd1);
    memRead_E = 1; rd_E = 0; rs1_D = 0;
    step("loaduse_x0");
    clear_inputs();

    // Forwarding priority M over W.
    regWrite_M = 1; rd_M = 3; regWrite_W = 1; rd_W = 3; rs1_E = 3; rs2_E = 7;
    step("fwd_M");
    chk("fwd_M_const", {30'd0, fwdA_E}, 32'd2);
    regWrite_M = 0;
    step("fwd_W");
    chk("fwd_W_const", {30'd0, fwdA_E}, 32'd1);
    clear_inputs();

    // Branch with simultaneous load-use.
    pcSrc_E = 1; memRead_E = 1; rd_E = 6; rs2_D = 6;
    step("branch_loaduse");
    chk("branch_count", {16'd0, stallCount}, 32'd1);
    clear_inputs();

    // Three-cycle memory wait, then ready.
    memAccess_M = 1;
    for (int i = 0; i < 3; i++) step("memwait");
    memReady = 1;
    step("memready");
    chk("memwait_count", {16'd0, stallCount}, 32'd4);
    // A second short wait must not inherit the earlier run length.
    memReady = 0;
    for (int i = 0; i < 3; i++) step("memwait2");
    memAccess_M = 0;
    step("memdrop");

    // Timeout: hold stall until error, then ready does not release.
    memAccess_M = 1; memReady = 0;
    for (int i = 0; i < 6; i++) step("timeout");
    chk("timeout_memErr", {31'd0, memErr}, 32'd1);
    memReady = 1;
    step("err_hold");
    chk("err_hold_enM", {31'd0, en_M}, 32'd0);
    step("err_hold2");
    clear_inputs(); rst = 1;
    step("err_reset");
    rst = 0;
    step("after_reset");
    chk("after_reset_memErr", {31'd0, memErr}, 32'd0);
    chk("after_reset_count", {16'd0, stallCount}, 32'd0);

    // Saturation of the narrow counter.
    memRead_E = 1; rd_E = 9; rs1_D = 9;
    for (int i = 0; i < 10; i++) step("saturate");
    chk("sat_final", {29'd0, s_stallCount}, 32'd7);
    chk("wide_final", {16'd0, stallCount}, 32'd10);
    clear_inputs();

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
      rd_W  = 5'($urandom_range(0, 3));
      memRead_E = 1'($urandom); pcSrc_E = ($urandom_range(0, 3) == 0);
      regWrite_M = 1'($urandom); regWrite_W = 1'($urandom);
      memAccess_M = ($urandom_range(0, 2) == 0); memReady = 1'($urandom);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. Drives the en/clr inputs of every inter-stage pipeline register (F/D, D/E, E/M, M/W) and the PC enable, and produces the E-stage forwarding selects. Adds a sequential wait FSM for the multi-cycle data memory, with timeout detection and a saturating stall-cycle counter. Sits beside the datapath, feeding the control pins of each pipeline register.

Parameters:
ADDR_W, 5, register-file index width
MEM_TIMEOUT, 16, max consecutive memory-wait cycles before error (>=2)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rs1_D, rs2_D  in  ADDR_W  source regs in Decode
rs1_E, rs2_E, rd_E  in  ADDR_W  source/dest regs in Execute
memRead_E  in  1  E-stage instruction is a load
pcSrc_E  in  1  branch/jump taken, resolved in Execute
rd_M, rd_W  in  ADDR_W  dest regs in Memory/Writeback
regWrite_M, regWrite_W  in  1  write-enable in Memory/Writeback
memAccess_M  in  1  M-stage instruction accesses data memory
memReady  in  1  data memory completes this cycle
en_F, en_D, en_E, en_M  out  1  enables: PC, F/D, D/E, E/M registers
clr_D, clr_E, clr_W  out  1  sync clears: F/D, D/E, M/W registers
fwdA_E, fwdB_E  out  2  forward select: 00 regfile, 01 from W, 10 from M
memErr  out  1  sticky memory-timeout flag
stallCount  out  CNT_W  cycles in which en_F was 0

Behaviour:
- Reset: synchronous on clk with rst=1. FSM->IDLE, wait counter=0, memErr=0, stallCount=0. While rst=1, outputs are forced: en_*=1, clr_*=0, fwd*=00.
- Forwarding (combinational, all states): fwdA_E=10 if regWrite_M && rd_M!=0 && rd_M==rs1_E; else 01 if regWrite_W && rd_W!=0 && rd_W==rs1_E; else 00. fwdB_E is identical using rs2_E. M beats W.
- loadUse = memRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
- memStall = memAccess_M && !memReady.
- FSM states: IDLE, WAIT, ERR.
  - IDLE: memStall -> WAIT, waitCnt=1.
  - WAIT: memReady -> IDLE, waitCnt=0. memStall with waitCnt==MEM_TIMEOUT-1 -> ERR. Otherwise waitCnt++.
  - Leaving WAIT when memAccess_M drops without memReady goes to IDLE.
  - ERR: absorbing until rst. memErr=1 (registered, asserted the cycle after entry).
- Output priority, highest first:
  1. State ERR: en_F=en_D=en_E=en_M=0, clr_*=0.
  2. memStall in IDLE or WAIT: en_F=en_D=en_E=en_M=0, clr_W=1 (bubble into W), clr_D=clr_E=0. Branch and loadUse are ignored this cycle; they are re-evaluated once the stall releases.
  3. pcSrc_E: clr_D=1, clr_E=1, all en=1. This also covers a simultaneous loadUse, because the dependent instruction is flushed.
  4. loadUse: en_F=en_D=0, clr_E=1, en_E=en_M=1.
  5. Otherwise: all en=1, all clr=0.
- No added latency: all control outputs are combinational from inputs and current state. The stall resolves in the same cycle memReady=1.
- stallCount increments at clk when en_F==0 and not rst. It saturates at 2^CNT_W-1 and does not wrap. ERR-state cycles are counted.

Test Plan:
- Load-use: memRead_E=1, rd_E=5, rs1_D=5 -> en_F=en_D=0, clr_E=1 for exactly 1 cycle; stallCount 0->1. Repeat with rd_E=0 -> no stall.
- Forwarding: regWrite_M=1, rd_M=3; regWrite_W=1, rd_W=3; rs1_E=3, rs2_E=7 -> fwdA_E=10, fwdB_E=00. Drop regWrite_M -> fwdA_E=01.
- Branch + load-use in the same cycle: pcSrc_E=1 with loadUse conditions true -> clr_D=clr_E=1, en_F=1, stallCount unchanged.
- Memory wait: memAccess_M=1, memReady=0 for 3 cycles, then 1 -> en_F..en_M=0 and clr_W=1 for 3 cycles; 4th cycle all en=1; stallCount=3; FSM back in IDLE.
- Timeout: MEM_TIMEOUT=4, memReady held 0 -> ERR entered after 4 stall cycles; memErr=1 from the next cycle; en_*=0 stays held even after memReady=1. Assert rst for 1 cycle -> memErr=0, stallCount=0, en_*=1.
- Saturation: CNT_W=3, hold loadUse for 10 cycles -> stallCount reaches 7 and stays at 7.
